// File: rtl/text_console_writer.sv
// Byte-stream text console: writes {attr,char} cells into character RAM, tracks the
// cursor, handles CR/LF/BS/FF and scrolls the screen up one row by RAM copy.
module text_console_writer #(
  parameter int         N_COL          = 80,
  parameter int         N_ROW          = 30,
  parameter int         TEXTADDR_WIDTH = 12,
  parameter logic [7:0] DEFAULT_ATTR   = 8'h0F
) (
  input  logic        cpu_clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  output logic        in_ready,
  input  logic        attr_we,
  input  logic [7:0]  attr_in,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic        ram_oe,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic [7:0]  cur_col,
  output logic [7:0]  cur_row,
  output logic        busy
);
  localparam int AW = TEXTADDR_WIDTH;
  localparam logic [7:0]    LAST_COL   = 8'(N_COL - 1);
  localparam logic [7:0]    LAST_ROW   = 8'(N_ROW - 1);
  localparam logic [AW-1:0] LAST_CELL  = AW'(N_COL * N_ROW - 1);
  localparam logic [AW-1:0] LAST_COPY  = AW'(N_COL * (N_ROW - 1) - 1);
  localparam logic [AW-1:0] ROW_STRIDE = AW'(N_COL);
  localparam logic [AW-1:0] SRC_STEP   = AW'(N_COL + 1);

  typedef enum logic [2:0] {IDLE, PUT, SCR_RD, SCR_WR, SCR_CLR, FILL} state_t;

  state_t        state_r, state_s;
  logic [7:0]    col_r, col_s, row_r, row_s;
  logic [7:0]    attr_r, attr_s, op_attr_r, op_attr_s;
  logic [AW-1:0] addr_r, addr_s;
  logic          we_r, we_s, oe_r, oe_s;
  logic [15:0]   wdata_r, wdata_s;
  logic          printable_s;

  function automatic logic [AW-1:0] cell_addr(input logic [7:0] row, input logic [7:0] col);
    cell_addr = AW'(32'(row) * 32'(N_COL) + 32'(col));
  endfunction

  assign printable_s = (in_char >= 8'h20) && (in_char <= 8'h7E);

  // Next-state, cursor and RAM-strobe computation
  always_comb begin
    state_s   = state_r;
    col_s     = col_r;
    row_s     = row_r;
    op_attr_s = op_attr_r;
    addr_s    = addr_r;
    we_s      = 1'b0;
    oe_s      = 1'b0;
    wdata_s   = wdata_r;
    if (attr_we) begin
      attr_s = attr_in;
    end else begin
      attr_s = attr_r;
    end
    case (state_r)
      IDLE: begin
        if (!in_valid) begin
          state_s = IDLE;
        end else if (printable_s) begin
          state_s = PUT;
          we_s    = 1'b1;
          addr_s  = cell_addr(row_r, col_r);
          wdata_s = {attr_r, in_char};
        end else if (in_char == 8'h0A) begin
          col_s = 8'h00;
          if (row_r == LAST_ROW) begin
            state_s   = SCR_RD;
            oe_s      = 1'b1;
            addr_s    = ROW_STRIDE;
            op_attr_s = attr_r;
          end else begin
            row_s = row_r + 8'h01;
          end
        end else if (in_char == 8'h0D) begin
          col_s = 8'h00;
        end else if (in_char == 8'h08) begin
          if (col_r != 8'h00) begin
            col_s = col_r - 8'h01;
          end else begin
            col_s = col_r;
          end
        end else if (in_char == 8'h0C) begin
          state_s   = FILL;
          we_s      = 1'b1;
          addr_s    = '0;
          wdata_s   = {attr_r, 8'h20};
          op_attr_s = attr_r;
        end else begin
          state_s = IDLE;
        end
      end
      PUT: begin
        if (col_r != LAST_COL) begin
          col_s   = col_r + 8'h01;
          state_s = IDLE;
        end else if (row_r != LAST_ROW) begin
          col_s   = 8'h00;
          row_s   = row_r + 8'h01;
          state_s = IDLE;
        end else begin
          // Wrapping off the bottom-right cell scrolls; cursor parks at the last row
          col_s     = 8'h00;
          state_s   = SCR_RD;
          oe_s      = 1'b1;
          addr_s    = ROW_STRIDE;
          op_attr_s = attr_r;
        end
      end
      SCR_RD: begin
        state_s = SCR_WR;
        we_s    = 1'b1;
        addr_s  = addr_r - ROW_STRIDE;
      end
      SCR_WR: begin
        if (addr_r == LAST_COPY) begin
          state_s = SCR_CLR;
          we_s    = 1'b1;
          addr_s  = addr_r + AW'(1);
          wdata_s = {op_attr_r, 8'h20};
        end else begin
          state_s = SCR_RD;
          oe_s    = 1'b1;
          addr_s  = addr_r + SRC_STEP;
        end
      end
      SCR_CLR, FILL: begin
        if (addr_r == LAST_CELL) begin
          state_s = IDLE;
          if (state_r == FILL) begin
            col_s = 8'h00;
            row_s = 8'h00;
          end else begin
            col_s = col_r;
          end
        end else begin
          we_s    = 1'b1;
          addr_s  = addr_r + AW'(1);
          wdata_s = {op_attr_r, 8'h20};
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, cursor, attribute and RAM output registers
  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      col_r     <= 8'h00;
      row_r     <= 8'h00;
      attr_r    <= DEFAULT_ATTR;
      op_attr_r <= DEFAULT_ATTR;
      addr_r    <= '0;
      we_r      <= 1'b0;
      oe_r      <= 1'b0;
      wdata_r   <= 16'h0000;
    end else begin
      state_r   <= state_s;
      col_r     <= col_s;
      row_r     <= row_s;
      attr_r    <= attr_s;
      op_attr_r <= op_attr_s;
      addr_r    <= addr_s;
      we_r      <= we_s;
      oe_r      <= oe_s;
      wdata_r   <= wdata_s;
    end
  end

  // Scroll copy data arrives the cycle after the read, so it is forwarded straight through
  assign ram_wdata = (state_r == SCR_WR) ? ram_rdata : wdata_r;
  assign ram_addr  = 16'(addr_r);
  assign ram_we    = we_r;
  assign ram_oe    = oe_r;
  assign cur_col   = col_r;
  assign cur_row   = row_r;
  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: screen/RAM model predicts every bus cycle and the
// cursor; directed literal checks pin the model on the key scenarios.
module tb_text_console_writer;
  localparam int N_COL = 80;
  localparam int N_ROW = 30;
  localparam int N_CELLS = N_COL * N_ROW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic        attr_we = 1'b0;
  logic [7:0]  attr_in = 8'h00;
  logic        in_ready, ram_we, ram_oe, busy;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic [7:0]  cur_col, cur_row;

  always #5 clk = ~clk;

  text_console_writer dut (
    .cpu_clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_char(in_char),
    .in_ready(in_ready), .attr_we(attr_we), .attr_in(attr_in),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
  );

  typedef struct packed {
    logic        we;
    logic        oe;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          rd_idx = 0;
  int          flush_idx = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;
  bit          preload = 1'b0;
  logic [15:0] ram [0:4095];
  logic [15:0] model_mem [0:N_CELLS-1];
  int          m_row, m_col;
  logic [7:0]  m_attr;

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 37 + 1280);
  endfunction

  // Behavioural character RAM: read data appears the cycle after ram_oe
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
    end else begin
      if (ram_we) ram[ram_addr[11:0]] <= ram_wdata;
      if (ram_oe) ram_rdata <= ram[ram_addr[11:0]];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- screen model ----------------
  task automatic push_w(input int a, input logic [15:0] d);
    exp_q.push_back('{1'b1, 1'b0, 16'(a), d});
    model_mem[a] = d;
  endtask

  task automatic push_r(input int a);
    exp_q.push_back('{1'b0, 1'b1, 16'(a), 16'h0000});
  endtask

  task automatic model_scroll();
    for (int s = N_COL; s < N_CELLS; s++) begin
      push_r(s);
      push_w(s - N_COL, model_mem[s]);
    end
    for (int a = N_CELLS - N_COL; a < N_CELLS; a++) push_w(a, {m_attr, 8'h20});
    m_row = N_ROW - 1;
    m_col = 0;
  endtask

  task automatic model_accept(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      int pos;
      pos = m_row * N_COL + m_col;
      push_w(pos, {m_attr, c});
      pos = pos + 1;
      if (pos == N_CELLS) model_scroll();
      else begin
        m_row = pos / N_COL;
        m_col = pos % N_COL;
      end
    end else if (c == 8'h0A) begin
      if (m_row == N_ROW - 1) model_scroll();
      else begin
        m_row = m_row + 1;
        m_col = 0;
      end
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h08) begin
      if (m_col > 0) m_col = m_col - 1;
    end else if (c == 8'h0C) begin
      for (int a = 0; a < N_CELLS; a++) push_w(a, {m_attr, 8'h20});
      m_row = 0;
      m_col = 0;
    end
  endtask

  // Per-cycle comparison of the RAM bus, handshake and cursor against the model
  always @(negedge clk) begin : cmp
    int k;
    exp_t e;
    logic [63:0] act, expv;
    k = (rd_idx < flush_idx) ? flush_idx : rd_idx;
    if (chk_en) begin
      if (k < exp_q.size()) begin
        e = exp_q[k];
        act  = {28'h0, busy, in_ready, ram_we, ram_oe, ram_addr, (e.we ? ram_wdata : 16'h0000)};
        expv = {28'h0, 1'b1, 1'b0, e.we, e.oe, e.addr, (e.we ? e.data : 16'h0000)};
        check("bus_cycle", act, expv);
        rd_idx <= k + 1;
      end else begin
        act  = {28'h0, busy, in_ready, ram_we, ram_oe, 16'h0000, cur_row, cur_col};
        expv = {28'h0, 4'b0100, 16'h0000, 8'(m_row), 8'(m_col)};
        check("idle_cursor", act, expv);
        rd_idx <= k;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] c, input bit with_attr = 1'b0, input logic [7:0] a = 8'h00);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20000) begin
      n++;
      @(negedge clk);
    end
    check("send_ready", 64'(in_ready), 64'h1);
    in_valid = 1'b1;
    in_char  = c;
    attr_we  = with_attr;
    attr_in  = a;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    attr_we  = 1'b0;
    model_accept(c);
    if (with_attr) m_attr = a;
  endtask

  task automatic set_attr(input logic [7:0] a);
    @(negedge clk);
    attr_we = 1'b1;
    attr_in = a;
    @(posedge clk);
    #1;
    attr_we = 1'b0;
    m_attr  = a;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 20000) begin
      n++;
      @(negedge clk);
    end
    check("wait_idle", 64'(busy), 64'h0);
  endtask

  task automatic check_cursor(input string name, input int row, input int col);
    check(name, {48'h0, cur_row, cur_col}, {48'h0, 8'(row), 8'(col)});
  endtask

  initial begin
    int n, q0;
    for (int i = 0; i < N_CELLS; i++) model_mem[i] = init_val(i);
    m_row = 0;
    m_col = 0;
    m_attr = 8'h0F;
    preload = 1'b1;
    repeat (3) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    check("rst_outputs", {28'h0, busy, in_ready, ram_we, ram_oe, ram_addr, ram_wdata},
          {28'h0, 4'b0100, 16'h0000, 16'h0000});
    check_cursor("rst_cursor", 0, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // single 'A' at home
    send(8'h41);
    @(negedge clk);
    check("a_write", {31'h0, ram_we, ram_addr, ram_wdata}, {31'h0, 1'b1, 16'h0000, 16'h0F41});
    @(negedge clk);
    check_cursor("a_cursor", 0, 1);

    // a full row of printables from column 0
    send(8'h0D);
    for (int i = 0; i < N_COL; i++) send(8'h20 + 8'(i));
    @(negedge clk);
    check("row_last_addr", {47'h0, ram_we, ram_addr}, {47'h0, 1'b1, 16'd79});
    wait_idle();
    check_cursor("row_cursor", 1, 0);

    // backspace at column 0, CR and ignored byte, backspace mid-row
    send(8'h0A);
    send(8'h0A);
    send(8'h08);
    @(negedge clk);
    check("bs_col0", {55'h0, ram_we, cur_row, cur_col}, {55'h0, 1'b0, 8'd3, 8'd0});
    send(8'h0D);
    send(8'h07);
    send(8'h78);
    send(8'h79);
    send(8'h08);
    @(negedge clk);
    check_cursor("bs_mid", 3, 1);

    // LF on the last row scrolls
    for (int i = 0; i < 26; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
    wait_idle();
    check_cursor("pre_scroll_cursor", 29, 5);
    q0 = exp_q.size();
    send(8'h0A);
    check("model_scroll_len", 64'(exp_q.size() - q0), 64'd4720);
    n = 0;
    @(negedge clk);
    check("scroll_first_rd", {46'h0, ram_oe, ram_we, ram_addr}, {46'h0, 2'b10, 16'd80});
    while (busy && n < 6000) begin
      n++;
      @(negedge clk);
    end
    check("scroll_busy_cycles", 64'(n), 64'd4720);
    check_cursor("scroll_cursor", 29, 0);

    // wrapping off the last cell also scrolls
    for (int i = 0; i < N_COL; i++) send(8'h30 + 8'(i % 10));
    wait_idle();
    check_cursor("wrap_scroll_cursor", 29, 0);

    // form feed with a new attribute; attribute change mid-fill must not leak in
    set_attr(8'h1E);
    send(8'h0C);
    @(negedge clk);
    check("fill_first", {31'h0, ram_we, ram_addr, ram_wdata}, {31'h0, 1'b1, 16'h0000, 16'h1E20});
    repeat (100) @(negedge clk);
    set_attr(8'h2A);
    wait_idle();
    check_cursor("fill_cursor", 0, 0);

    // byte accepted with attr_we uses the previous attribute
    send(8'h42, 1'b1, 8'h3C);
    @(negedge clk);
    check("attr_same_edge", {32'h0, ram_addr, ram_wdata}, {32'h0, 16'h0000, 16'h2A42});
    send(8'h43);
    @(negedge clk);
    check("attr_next", {32'h0, ram_addr, ram_wdata}, {32'h0, 16'h0001, 16'h3C43});

    // reset in the middle of a scroll
    for (int i = 0; i < 29; i++) send(8'h0A);
    send(8'h0A);
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    flush_idx = exp_q.size();
    m_row = 0;
    m_col = 0;
    m_attr = 8'h0F;
    @(negedge clk);
    check("midrst_outputs", {28'h0, busy, in_ready, ram_we, ram_oe, ram_addr, ram_wdata},
          {28'h0, 4'b0100, 16'h0000, 16'h0000});
    check_cursor("midrst_cursor", 0, 0);
    rst_n = 1'b1;
    send(8'h5A);
    @(negedge clk);
    check("post_rst_attr", {32'h0, ram_addr, ram_wdata}, {32'h0, 16'h0000, 16'h0F5A});
    wait_idle();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 Parameter N_COL, default 80, text columns.
REQ-002 Parameter N_ROW, default 30, text rows.
REQ-003 Parameter TEXTADDR_WIDTH, default 12, character RAM address width (clog2(N_COL*N_ROW)).
REQ-004 Parameter DEFAULT_ATTR, default 8'h0F, attribute loaded at reset.
REQ-005 cpu_clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset; synchronous, active-low.
REQ-007 in_valid  in  1  input byte offered.
REQ-008 in_char  in  8  ASCII byte.
REQ-009 in_ready  out  1  byte accepted when in_valid and in_ready are both high on an edge.
REQ-010 attr_we  in  1  load attr_in as current attribute.
REQ-011 attr_in  in  8  new attribute (fg/bg).
REQ-012 ram_addr  out  16  character RAM address; upper bits above TEXTADDR_WIDTH are zero.
REQ-013 ram_we  out  1  character RAM write strobe.
REQ-014 ram_oe  out  1  character RAM read strobe.
REQ-015 ram_wdata  out  16  {attribute[7:0], char[7:0]} written to RAM.
REQ-016 ram_rdata  in  16  RAM read data, valid the cycle after ram_oe.
REQ-017 cur_col  out  8  cursor column; cur_row  out  8  cursor row.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 States: IDLE, PUT, SCR_RD, SCR_WR, SCR_CLR, FILL.
REQ-020 in_ready is high only in IDLE; busy equals not in_ready.
REQ-021 Cell address = row*N_COL + col.
REQ-022 Printable byte (0x20-0x7E) accepted at edge T: edge T+1 writes {attr, char} at cursor (PUT, ram_we high exactly one cycle), then cursor advances.
REQ-023 Advance: col+1; at col N_COL-1 wrap to col 0, row+1; at row N_ROW-1 the wrap triggers a scroll and leaves cursor at (N_ROW-1, 0).
REQ-024 0x0A (LF): col=0, row+1; on last row triggers scroll, no character write.
REQ-025 0x0D (CR): col=0, no write, one cycle back to IDLE.
REQ-026 0x08 (BS): col-1 if col>0, otherwise unchanged; never moves rows; no write.
REQ-027 0x0C (FF): FILL writes {attr,8'h20} to every cell 0..N_COL*N_ROW-1, one per cycle, ascending; cursor then (0,0).
REQ-028 All other bytes are consumed with no RAM or cursor effect.
REQ-029 Scroll: for each source cell s = N_COL .. N_COL*N_ROW-1 ascending, SCR_RD drives ram_oe at s; next cycle SCR_WR writes ram_rdata to s-N_COL; 2 cycles per cell.
REQ-030 After copy, SCR_CLR writes {attr,8'h20} to the N_COL cells of the last row, one per cycle; then IDLE.
REQ-031 Scroll duration from first SCR_RD to return to IDLE: 2*N_COL*(N_ROW-1)+N_COL cycles (4720 at defaults).
REQ-032 ram_we and ram_oe are never high together; both are low in IDLE.
REQ-033 attr_we is honoured in any state; a byte accepted on the same edge as attr_we uses the previous attribute; fills/clears in progress use the attribute latched at their start.
REQ-034 Cursor outputs update on the edge that completes the operation; values never exceed N_COL-1 / N_ROW-1.

Reset
REQ-035 With rst_n low at an edge: state IDLE, cursor (0,0), attribute DEFAULT_ATTR, ram_we=0, ram_oe=0, ram_addr=0, ram_wdata=0, busy=0, in_ready=1 on the following cycle.
REQ-036 Reset aborts any scroll or fill mid-operation; RAM contents are not restored or cleared.

Verification
REQ-037 Reset, send 'A' (0x41) -> one write, ram_addr=0, ram_wdata=16'h0F41; cursor (0,1).
REQ-038 Send 80 printables from (0,0) -> last write at addr 79; cursor (1,0); no scroll.
REQ-039 Cursor (29,5), send 0x0A -> 2320 reads/2320 writes then 80 writes of 16'h0F20 at addr 2320..2399; busy high exactly 4720 cycles; cursor (29,0).
REQ-040 attr_we with 8'h1E, then 0x0C -> 2400 consecutive writes of 16'h1E20 at addr 0..2399; cursor (0,0).
REQ-041 Cursor (3,0), send 0x08 -> cursor stays (3,0), no write; then 0x0D and 0x07 -> no RAM activity.
REQ-042 Assert rst_n low mid-scroll -> next cycle ram_we=0, ram_oe=0, cursor (0,0), in_ready=1.
